dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL provide parameter ADDR_W, default 32, meaning width of request and memory address.
REQ-002 SHALL provide parameter DATA_W, default 32, meaning width of write and read data.
REQ-003 SHALL provide port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL provide port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL provide, for n in {0,1}: reqN_valid input 1; reqN_ready output 1; reqN_we input 1; reqN_addr input ADDR_W; reqN_wdata input DATA_W.
REQ-006 SHALL provide, for n in {0,1}: rspN_valid output 1; rspN_ready input 1; rspN_rdata output DATA_W.
REQ-007 SHALL provide mem_we output 1, mem_addr output ADDR_W, mem_wdata output DATA_W and mem_rdata input DATA_W. The shared data memory writes on the clock edge and reads combinationally.
REQ-008 SHALL provide port busy  output  1, high in any state other than IDLE.

Function
REQ-009 SHALL implement FSM states IDLE, ACCESS and RESP. Transitions:
  - IDLE->ACCESS on an accepted request.
  - ACCESS->RESP unconditionally.
  - RESP->IDLE when rspG_ready=1, where G is the latched grant.
REQ-010 SHALL assert reqN_ready only in IDLE and only for the selected requester. The other reqN_ready SHALL be 0.
REQ-011 SHALL define acceptance as reqN_valid & reqN_ready in the same cycle. On acceptance, latch we, addr, wdata and grant id G.
REQ-012 SHALL, in ACCESS only, drive mem_addr and mem_wdata from the latched values and drive mem_we equal to the latched we. In all other states mem_we SHALL be 0 and mem_addr and mem_wdata SHALL be 0.
REQ-013 SHALL, at the end of ACCESS, capture mem_rdata for reads, or 0 for writes, into a response register.
REQ-014 SHALL, in RESP, assert rspG_valid and drive rspG_rdata from the response register. The other requester's rsp_valid SHALL be 0 and its rdata SHALL be 0.
REQ-015 SHALL hold rspG_valid and rspG_rdata stable until rspG_ready=1. The transaction completes in the cycle where rspG_valid and rspG_ready are both 1.
REQ-016 SHALL give minimum latency of 2 cycles: accept at edge N, memory access cycle N+1, rsp_valid visible in cycle N+2.
REQ-017 SHALL accept at most one transaction per 3 cycles, with no overlap between transactions.
REQ-018 SHALL, when only one reqN_valid is high in IDLE, select that requester.
REQ-019 SHALL, when both are high in IDLE, select per the arbitration policy in REQ-025/026.
REQ-020 SHALL ignore reqN_* changes after acceptance. A requester dropping valid before acceptance SHALL NOT be granted.
REQ-021 SHALL pass addresses through unmodified; the arbiter performs no alignment checking.

Reset
REQ-022 SHALL, while rst_n=0, force the following immediately and asynchronously: state=IDLE, mem_we=0, all reqN_ready=0, all rspN_valid=0, all rspN_rdata=0, mem_addr=0, mem_wdata=0, busy=0, RR pointer=0.
REQ-023 SHALL discard any in-flight transaction on reset assertion. A write in ACCESS when reset is asserted SHALL have mem_we dropped before the next clock edge.
REQ-024 SHALL allow acceptance on the first rising edge after rst_n deasserts, provided the corresponding reqN_valid=1.

Configuration
REQ-025 SHALL, with macro DMEM_ARB_RR_EN defined, use round-robin arbitration on contention.
  - A 1-bit pointer names the preferred requester; it resets to 0 (requester 0 preferred).
  - After every acceptance, the pointer SHALL be set to the requester not granted.
REQ-026 SHALL, without DMEM_ARB_RR_EN, use fixed priority: requester 0 always wins contention, and no pointer register exists.

Verification
REQ-027 SHALL cover a single read:
  - Stimulus: memory word 0x10 preloaded with 0xDEADBEEF; req0 read addr 0x10; rsp0_ready=1.
  - Response: req0_ready=1 at cycle 0; mem_we=0 and mem_addr=0x10 at cycle 1; rsp0_valid=1 and rsp0_rdata=0xDEADBEEF at cycle 2; IDLE at cycle 3.
REQ-028 SHALL cover a write then read:
  - Stimulus: req1 write addr 0x20 data 0x12345678, then req1 read addr 0x20.
  - Response: mem_we=1 for exactly one cycle; write response rdata=0; read response rdata=0x12345678.
REQ-029 SHALL cover contention with DMEM_ARB_RR_EN:
  - Stimulus: both valid continuously for 4 transactions.
  - Response: grant order 0,1,0,1.
  - Same stimulus without the macro: grant order 0,0,0,0, and req1_ready never asserted.
REQ-030 SHALL cover response backpressure:
  - Stimulus: rsp0_ready=0 for 5 cycles after rsp0_valid rises.
  - Response: rsp0_valid and rdata held constant; req1_ready=0 throughout; IDLE the cycle after rsp0_ready=1.
REQ-031 SHALL cover reset during ACCESS:
  - Stimulus: req0 write addr 0x30 data 0xAAAA5555 accepted; rst_n pulsed low mid-ACCESS cycle before the edge.
  - Response: mem_we falls immediately; memory at 0x30 unchanged; no rsp0_valid after reset release.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter in front of a single-port data memory: IDLE -> ACCESS -> RESP per transaction.
// Define DMEM_ARB_RR_EN for round-robin contention handling; otherwise requester 0 has fixed priority.
module dmem_arbiter #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req0_valid,
   output logic              req0_ready,
   input  logic              req0_we,
   input  logic [ADDR_W-1:0] req0_addr,
   input  logic [DATA_W-1:0] req0_wdata,
   input  logic              req1_valid,
   output logic              req1_ready,
   input  logic              req1_we,
   input  logic [ADDR_W-1:0] req1_addr,
   input  logic [DATA_W-1:0] req1_wdata,
   output logic              rsp0_valid,
   input  logic              rsp0_ready,
   output logic [DATA_W-1:0] rsp0_rdata,
   output logic              rsp1_valid,
   input  logic              rsp1_ready,
   output logic [DATA_W-1:0] rsp1_rdata,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy
);

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

   state_t              state, state_nxt;
   logic                grant;
   logic                lat_we;
   logic [ADDR_W-1:0]   lat_addr;
   logic [DATA_W-1:0]   lat_wdata;
   logic [DATA_W-1:0]   rsp_data;
   logic                prefer1;
   logic                sel1;
   logic                accept;
   logic                rsp_ready_g;

`ifdef DMEM_ARB_RR_EN
   logic rr_ptr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         rr_ptr <= 1'b0;
      else if (accept)
         rr_ptr <= ~sel1;
   end

   assign prefer1 = rr_ptr;
`else
   assign prefer1 = 1'b0;
`endif

   // Ready is gated by rst_n so both requesters see 0 the instant reset asserts.
   assign sel1       = req1_valid & (~req0_valid | prefer1);
   assign req0_ready = rst_n & (state == IDLE) & req0_valid & ~sel1;
   assign req1_ready = rst_n & (state == IDLE) & sel1;
   assign accept     = req0_ready | req1_ready;
   assign rsp_ready_g = grant ? rsp1_ready : rsp0_ready;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         grant     <= 1'b0;
         lat_we    <= 1'b0;
         lat_addr  <= '0;
         lat_wdata <= '0;
         rsp_data  <= '0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            grant     <= sel1;
            lat_we    <= sel1 ? req1_we    : req0_we;
            lat_addr  <= sel1 ? req1_addr  : req0_addr;
            lat_wdata <= sel1 ? req1_wdata : req0_wdata;
         end
         if (state == ACCESS)
            rsp_data <= lat_we ? '0 : mem_rdata;
      end
   end

   // NOTE: every output gets a default first so no path through the case infers a latch.
   always_comb begin
      state_nxt  = state;
      busy       = 1'b0;
      mem_we     = 1'b0;
      mem_addr   = '0;
      mem_wdata  = '0;
      rsp0_valid = 1'b0;
      rsp1_valid = 1'b0;
      rsp0_rdata = '0;
      rsp1_rdata = '0;
      case (state)
         IDLE: begin
            if (accept)
               state_nxt = ACCESS;
         end
         ACCESS: begin
            busy      = 1'b1;
            mem_we    = lat_we;
            mem_addr  = lat_addr;
            mem_wdata = lat_wdata;
            state_nxt = RESP;
         end
         RESP: begin
            busy = 1'b1;
            if (grant) begin
               rsp1_valid = 1'b1;
               rsp1_rdata = rsp_data;
            end else begin
               rsp0_valid = 1'b1;
               rsp0_rdata = rsp_data;
            end
            if (rsp_ready_g)
               state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter with a small behavioural memory.
// Expected grant order follows DMEM_ARB_RR_EN, matching the build of the design.
module tb_dmem_arbiter;

`ifdef DMEM_ARB_RR_EN
   localparam bit RR_EN = 1'b1;
`else
   localparam bit RR_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req0_valid, req0_ready, req0_we;
   logic [31:0] req0_addr, req0_wdata;
   logic        req1_valid, req1_ready, req1_we;
   logic [31:0] req1_addr, req1_wdata;
   logic        rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
   logic [31:0] rsp0_rdata, rsp1_rdata;
   logic        mem_we, busy;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;

   logic [31:0] mem [0:255];
   logic        preload;
   int          we_cnt = 0;
   int          checks = 0;
   int          failures = 0;

   always #5 clk = ~clk;

   dmem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we),
      .req0_addr(req0_addr), .req0_wdata(req0_wdata),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we),
      .req1_addr(req1_addr), .req1_wdata(req1_wdata),
      .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_rdata(rsp0_rdata),
      .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_rdata(rsp1_rdata),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .busy(busy)
   );

   assign mem_rdata = mem[mem_addr[7:0]];

   always @(posedge clk) begin
      if (preload) begin
         for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
         mem[8'h10] <= 32'hDEADBEEF;
         mem[8'h30] <= 32'h0BADF00D;
      end else if (mem_we) begin
         mem[mem_addr[7:0]] <= mem_wdata;
      end
   end

   always @(posedge clk) if (mem_we) we_cnt <= we_cnt + 1;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0;
      preload = 1'b1;
      req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 32'h10; req0_wdata = 32'h0;
      req1_valid = 1'b0; req1_we = 1'b0; req1_addr = 32'h0;  req1_wdata = 32'h0;
      rsp0_ready = 1'b1; rsp1_ready = 1'b1;
      step();
      preload = 1'b0;
      step();

      // Reset state with a pending request
      check("rst_req0_ready", req0_ready, 0);
      check("rst_busy", busy, 0);
      check("rst_mem_we", mem_we, 0);
      check("rst_rsp0_valid", rsp0_valid, 0);
      check("rst_mem_addr", mem_addr, 0);

      // Single read, accepted on first edge after reset release
      rst_n = 1'b1;
      #1;
      check("rd_req0_ready_c0", req0_ready, 1);
      check("rd_req1_ready_c0", req1_ready, 0);
      step();
      req0_valid = 1'b0;
      check("rd_busy_c1", busy, 1);
      check("rd_mem_we_c1", mem_we, 0);
      check("rd_mem_addr_c1", mem_addr, 32'h10);
      step();
      check("rd_rsp0_valid_c2", rsp0_valid, 1);
      check("rd_rsp0_rdata_c2", rsp0_rdata, 32'hDEADBEEF);
      check("rd_rsp1_valid_c2", rsp1_valid, 0);
      check("rd_rsp1_rdata_c2", rsp1_rdata, 0);
      check("rd_mem_addr_c2", mem_addr, 0);
      step();
      check("rd_idle_c3", busy, 0);

      // Write then read from requester 1
      req1_valid = 1'b1; req1_we = 1'b1; req1_addr = 32'h20; req1_wdata = 32'h12345678;
      #1;
      check("wr_req1_ready", req1_ready, 1);
      step();
      req1_valid = 1'b0; req1_we = 1'b0; req1_wdata = 32'hFFFF_FFFF;
      check("wr_mem_we", mem_we, 1);
      check("wr_mem_addr", mem_addr, 32'h20);
      check("wr_mem_wdata", mem_wdata, 32'h12345678);
      step();
      check("wr_mem_we_rsp", mem_we, 0);
      check("wr_rsp1_valid", rsp1_valid, 1);
      check("wr_rsp1_rdata", rsp1_rdata, 0);
      check("wr_mem_content", mem[8'h20], 32'h12345678);
      step();
      req1_valid = 1'b1; req1_we = 1'b0; req1_addr = 32'h20;
      step();
      req1_valid = 1'b0;
      check("wr_rd_mem_we", mem_we, 0);
      step();
      check("wr_rd_rsp1_rdata", rsp1_rdata, 32'h12345678);
      check("wr_we_cycles", we_cnt, 1);
      step();

      // Contention, four back-to-back transactions
      req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 32'h10;
      req1_valid = 1'b1; req1_we = 1'b0; req1_addr = 32'h20;
      #1;
      for (int i = 0; i < 4; i++) begin
         check($sformatf("arb_req0_ready_%0d", i), req0_ready, !(RR_EN && i % 2 == 1));
         check($sformatf("arb_req1_ready_%0d", i), req1_ready, (RR_EN && i % 2 == 1));
         step();
         step();
         check($sformatf("arb_rsp_valid_%0d", i), {rsp1_valid, rsp0_valid},
               (RR_EN && i % 2 == 1) ? 2'b10 : 2'b01);
         step();
      end

      // Response backpressure on requester 0 while requester 1 waits
      rsp0_ready = 1'b0;
      #1;
      check("bp_req0_ready", req0_ready, 1);
      step();
      step();
      check("bp_rsp0_valid_rise", rsp0_valid, 1);
      for (int i = 0; i < 5; i++) begin
         step();
         check($sformatf("bp_rsp0_valid_%0d", i), rsp0_valid, 1);
         check($sformatf("bp_rsp0_rdata_%0d", i), rsp0_rdata, 32'hDEADBEEF);
         check($sformatf("bp_req1_ready_%0d", i), req1_ready, 0);
      end
      rsp0_ready = 1'b1;
      step();
      req0_valid = 1'b0; req1_valid = 1'b0;
      check("bp_idle_after_ready", busy, 0);
      check("bp_rsp0_valid_drop", rsp0_valid, 0);
      step();

      // Reset asserted mid-ACCESS of a write
      req0_valid = 1'b1; req0_we = 1'b1; req0_addr = 32'h30; req0_wdata = 32'hAAAA5555;
      step();
      req0_valid = 1'b0; req0_we = 1'b0;
      check("rstw_mem_we_access", mem_we, 1);
      #2;
      rst_n = 1'b0;
      #1;
      check("rstw_mem_we_async", mem_we, 0);
      check("rstw_busy_async", busy, 0);
      check("rstw_mem_addr_async", mem_addr, 0);
      step();
      rst_n = 1'b1;
      check("rstw_mem_unchanged", mem[8'h30], 32'h0BADF00D);
      for (int i = 0; i < 3; i++) begin
         step();
         check($sformatf("rstw_no_rsp0_%0d", i), rsp0_valid, 0);
      end
      check("rstw_we_total", we_cnt, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
